// File: rtl/apb_reg_bridge_if.sv
// APB4 slave plus register-bus request/acknowledge signals for apb_reg_bridge.
// Latency: none, this is a plain signal bundle.
// Backpressure: the register side stalls APB through wack/rack; APB itself has none.
interface apb_reg_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // APB side
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;
  // register-bus side
  logic [ADDR_W-1:0]   reg_addr;
  logic [DATA_W-1:0]   reg_wdata;
  logic [DATA_W/8-1:0] reg_wstrb;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   reg_rdata;
  logic                wack;
  logic                rack;
  logic                waddrerr;
  logic                raddrerr;

  // bridge view
  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr,
    output reg_addr, reg_wdata, reg_wstrb, wr_en, rd_en,
    input  reg_rdata, wack, rack, waddrerr, raddrerr
  );

  // APB master plus register file view
  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  reg_addr, reg_wdata, reg_wstrb, wr_en, rd_en,
    output reg_rdata, wack, rack, waddrerr, raddrerr
  );
endinterface

// File: rtl/apb_reg_bridge.sv
// APB4 slave to single-request register bus bridge (IDLE/REQ/WAIT/RESP); optional timeout via APB_REG_BRIDGE_TIMEOUT_EN.
// Latency: access phase is 3 cycles minimum (capture, request, response); misaligned addresses respond after 2.
// Backpressure: wait states are inserted until the matching wack/rack; with the timeout macro a stalled access errors out.
module apb_reg_bridge #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic             pclk,
  input logic             prst,
  apb_reg_bridge_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

  // reject illegal configurations at elaboration
  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("apb_reg_bridge: DATA_W must be 8, 16, 32 or 64");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_reg_bridge: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                write_q;
  logic [DATA_W-1:0]   prdata_q;
  logic                pslverr_q;

  logic start;
  logic misaligned;
  logic ack_match;
  logic ack_err;
  logic pending;
  logic timeout_hit;

  // a transfer is only accepted from IDLE, so transfers never overlap
  assign start      = (state_q == S_IDLE) && bus.psel && bus.penable;
  assign misaligned = (STRB_W > 1) ? (bus.paddr[LSB_W-1:0] != '0) : 1'b0;
  assign pending    = (state_q == S_REQ) || (state_q == S_WAIT);
  // only the acknowledge matching the captured direction counts
  assign ack_match  = write_q ? bus.wack : bus.rack;
  assign ack_err    = write_q ? bus.waddrerr : bus.raddrerr;

`ifdef APB_REG_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // count WAIT cycles since the request was issued
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      to_cnt_q <= '0;
    end else if (start) begin
      to_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  // the last allowed WAIT cycle without an ack forces an error response
  assign timeout_hit = (state_q == S_WAIT) && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic; acks seen in IDLE or RESP fall through unused
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = misaligned ? S_RESP : S_REQ;
      S_REQ:  state_d = ack_match ? S_RESP : S_WAIT;
      S_WAIT: if (ack_match || timeout_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // capture the APB request; strobes are zeroed for reads
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
    end else if (start) begin
      addr_q  <= bus.paddr;
      wdata_q <= bus.pwdata;
      wstrb_q <= bus.pwrite ? bus.pstrb : '0;
      write_q <= bus.pwrite;
    end
  end

  // register the response; a matching ack wins over a simultaneous timeout
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (start) begin
      prdata_q  <= '0;
      pslverr_q <= misaligned;
    end else if (pending && ack_match) begin
      prdata_q  <= (!write_q && !ack_err) ? bus.reg_rdata : '0;
      pslverr_q <= ack_err;
    end else if (timeout_hit) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b1;
    end
  end

  // outputs decoded from state; response fields are forced to zero outside RESP
  always_comb begin
    bus.pready    = (state_q == S_RESP);
    bus.prdata    = (state_q == S_RESP) ? prdata_q : '0;
    bus.pslverr   = (state_q == S_RESP) && pslverr_q;
    bus.wr_en     = (state_q == S_REQ) && write_q;
    bus.rd_en     = (state_q == S_REQ) && !write_q;
    bus.reg_addr  = addr_q;
    bus.reg_wdata = wdata_q;
    bus.reg_wstrb = wstrb_q;
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge with a scoreboard of expected responses.
// Latency: checks first-pready cycle against a reference model per transfer.
// Backpressure: acks are driven with programmable delay, wrong-type acks and no ack.
module tb_apb_reg_bridge;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = DATA_W / 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_CYC     = 60;
`ifdef APB_REG_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  apb_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                lat;
    int                n_wr;
    int                n_rd;
    logic [STRB_W-1:0] wstrb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference behaviour of one transfer; ack_dly counts cycles after the request cycle
  function automatic exp_t model(input logic [ADDR_W-1:0] a, input bit w, input logic [STRB_W-1:0] st,
                                 input int ack_dly, input bit err, input logic [DATA_W-1:0] rd);
    exp_t e;
    bit   timed;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; e.n_wr = 0; e.n_rd = 0; e.wstrb = '0;
    end else begin
      timed   = (ack_dly < 0) || (TO_EN && ack_dly > TIMEOUT_CYC);
      e.n_wr  = w ? 1 : 0;
      e.n_rd  = w ? 0 : 1;
      e.wstrb = w ? st : '0;
      e.err   = timed ? 1'b1 : err;
      e.rdata = (timed || w || err) ? '0 : rd;
      e.lat   = timed ? TIMEOUT_CYC + 2 : ack_dly + 2;
    end
    return e;
  endfunction

  task automatic clear_acks();
    bus.wack = 1'b0; bus.rack = 1'b0; bus.waddrerr = 1'b0; bus.raddrerr = 1'b0; bus.reg_rdata = '0;
  endtask

  task automatic apb_xfer(input logic [ADDR_W-1:0] a, input bit w, input logic [DATA_W-1:0] wd,
                          input logic [STRB_W-1:0] st, input int ack_dly, input bit err,
                          input logic [DATA_W-1:0] rd, input bit wrong_ack, input bit drop_early);
    exp_t              e;
    int                nwr, nrd, lat;
    bit                done, zero_ok;
    logic              got_err;
    logic [DATA_W-1:0] got_rdata;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    exp_q.push_back(model(a, w, st, ack_dly, err, rd));
    s_addr = 'x; s_wdata = 'x; s_wstrb = 'x; got_err = 1'bx; got_rdata = 'x;
    @(negedge pclk);
    bus.paddr = a; bus.pwrite = w; bus.pwdata = wd; bus.pstrb = st; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    done = 1'b0; zero_ok = 1'b1; nwr = 0; nrd = 0; lat = 0;
    for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
      @(negedge pclk);
      if (bus.wr_en || bus.rd_en) begin
        s_addr = bus.reg_addr; s_wdata = bus.reg_wdata; s_wstrb = bus.reg_wstrb;
      end
      if (bus.wr_en) nwr++;
      if (bus.rd_en) nrd++;
      if (bus.pready) begin
        done = 1'b1; lat = cyc + 1; got_err = bus.pslverr; got_rdata = bus.prdata;
      end else if (bus.prdata !== '0 || bus.pslverr !== 1'b0) begin
        zero_ok = 1'b0;
      end
      clear_acks();
      if (!done) begin
        if (cyc == ack_dly) begin
          if (w) begin bus.wack = 1'b1; bus.waddrerr = err; end
          else begin bus.rack = 1'b1; bus.raddrerr = err; bus.reg_rdata = rd; end
        end else if (wrong_ack && cyc < ack_dly) begin
          if (w) bus.rack = 1'b1; else bus.wack = 1'b1;
          bus.reg_rdata = 32'hBAD0_BAD0;
        end
        if (drop_early && cyc == 0) begin bus.psel = 1'b0; bus.penable = 1'b0; end
      end
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    clear_acks();
    e = exp_q.pop_front();
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL pready_timeout addr=%0h: no pready within %0d cycles", a, MAX_CYC);
    end else if (lat !== e.lat) begin
      n_fail++; $display("FAIL latency addr=%0h: got %0d want %0d", a, lat, e.lat);
    end
    n_tests++;
    if (got_err !== e.err) begin
      n_fail++; $display("FAIL pslverr addr=%0h: got %0b want %0b", a, got_err, e.err);
    end
    n_tests++;
    if (got_rdata !== e.rdata) begin
      n_fail++; $display("FAIL prdata addr=%0h: got %0h want %0h", a, got_rdata, e.rdata);
    end
    n_tests++;
    if (nwr !== e.n_wr || nrd !== e.n_rd) begin
      n_fail++; $display("FAIL strobe_count addr=%0h: got wr=%0d rd=%0d want wr=%0d rd=%0d", a, nwr, nrd, e.n_wr, e.n_rd);
    end
    n_tests++;
    if (!zero_ok) begin
      n_fail++; $display("FAIL resp_idle_zero addr=%0h: got nonzero prdata/pslverr without pready want 0", a);
    end
    if (e.n_wr + e.n_rd > 0) begin
      n_tests++;
      if (s_addr !== a || s_wstrb !== e.wstrb) begin
        n_fail++; $display("FAIL reg_addr_strb: got %0h/%0h want %0h/%0h", s_addr, s_wstrb, a, e.wstrb);
      end
      if (w) begin
        n_tests++;
        if (s_wdata !== wd) begin
          n_fail++; $display("FAIL reg_wdata: got %0h want %0h", s_wdata, wd);
        end
      end
    end
    @(negedge pclk);
  endtask

  task automatic check_quiet(input string tag);
    n_tests++;
    if ({bus.pready, bus.pslverr, bus.wr_en, bus.rd_en} !== 4'b0 || bus.prdata !== '0 ||
        bus.reg_addr !== '0 || bus.reg_wdata !== '0 || bus.reg_wstrb !== '0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%0b err=%0b wr=%0b rd=%0b prdata=%0h addr=%0h wdata=%0h wstrb=%0h want all 0",
               tag, bus.pready, bus.pslverr, bus.wr_en, bus.rd_en, bus.prdata, bus.reg_addr, bus.reg_wdata, bus.reg_wstrb);
    end
  endtask

  task automatic test_reset();
    prst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    clear_acks();
    @(negedge pclk);
    check_quiet("reset_state");
    @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    check_quiet("after_release");
  endtask

  task automatic test_write_ack_t1();
    apb_xfer(12'h010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait();
    apb_xfer(12'h004, 1'b0, 32'h1111_2222, 4'hF, 4, 1'b0, 32'h0000_00A5, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    apb_xfer(12'h7FC, 1'b0, '0, 4'h0, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    apb_xfer(12'h002, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b0, '0, 1'b0, 1'b0);
    apb_xfer(12'h021, 1'b0, '0, 4'h0, 0, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
    apb_xfer(12'h030, 1'b1, 32'h0BAD_0ADD, 4'h3, 2, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_ack();
    apb_xfer(12'h008, 1'b1, 32'h8765_4321, 4'hF, 3, 1'b0, '0, 1'b1, 1'b0);
    apb_xfer(12'h00C, 1'b1, 32'h00AB_0000, 4'h4, 1, 1'b0, '0, 1'b0, 1'b0);
    apb_xfer(12'h018, 1'b0, '0, 4'h0, 3, 1'b0, 32'h7777_0001, 1'b1, 1'b0);
    apb_xfer(12'h014, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    // with the timeout this errors after 16 WAIT cycles; without it the late ack completes it
    apb_xfer(12'h100, 1'b0, '0, 4'h0, 40, 1'b0, 32'h0000_0042, 1'b0, 1'b0);
    apb_xfer(12'h104, 1'b0, '0, 4'h0, TIMEOUT_CYC, 1'b0, 32'h0000_0043, 1'b0, 1'b0);
  endtask

  task automatic test_ack_in_idle();
    for (int i = 0; i < 4; i++) begin
      bus.wack = 1'b1; bus.rack = 1'b1; bus.raddrerr = 1'b1; bus.reg_rdata = 32'hFFFF_0000;
      @(negedge pclk);
      n_tests++;
      if ({bus.pready, bus.wr_en, bus.rd_en, bus.pslverr} !== 4'b0) begin
        n_fail++;
        $display("FAIL ack_in_idle: got rdy=%0b wr=%0b rd=%0b err=%0b want 0", bus.pready, bus.wr_en, bus.rd_en, bus.pslverr);
      end
    end
    clear_acks();
    @(negedge pclk);
  endtask

  task automatic test_apb_violation();
    apb_xfer(12'h040, 1'b1, 32'h1357_9BDF, 4'hF, 2, 1'b0, '0, 1'b0, 1'b1);
    apb_xfer(12'h044, 1'b0, '0, 4'h0, 1, 1'b0, 32'h2468_ACE0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    @(negedge pclk);
    bus.paddr = 12'h020; bus.pwrite = 1'b0; bus.pstrb = '0; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    @(posedge pclk);
    #2;
    prst = 1'b1;
    #1;
    check_quiet("async_reset_in_wait");
    bus.psel = 1'b0; bus.penable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      check_quiet("held_in_reset");
    end
    prst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_tests++;
      if (bus.pready !== 1'b0) begin
        n_fail++; $display("FAIL no_pready_after_reset: got %0b want 0", bus.pready);
      end
    end
    apb_xfer(12'h020, 1'b1, 32'hA5A5_5A5A, 4'hF, 1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      a = ADDR_W'($urandom_range(0, 1023) << 2);
      d = $urandom;
      apb_xfer(a, bit'($urandom_range(0, 1)), d, STRB_W'($urandom_range(0, 15)), $urandom_range(0, 5),
               ($urandom_range(0, 3) == 0), ~d, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack_t1();
    test_read_wait();
    test_errors();
    test_wrong_ack();
    test_timeout();
    test_ack_in_idle();
    test_apb_violation();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
